// File: rtl/mccomp_run_checker.sv
// mccomp_run_checker: reset, run and register-scan self-check controller for mccomp
module mccomp_run_checker #(
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 5,
  parameter int NUM_REGS   = 32,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16,
  parameter int SAMPLE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_limit,
  input  logic              halt_en,
  input  logic [DATA_W-1:0] halt_pc,
  input  logic [DATA_W-1:0] cpu_pc,
  output logic              cpu_rstn,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exp_we,
  input  logic [SEL_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              halted,
  output logic [SEL_W:0]    err_count,
  output logic [SEL_W-1:0]  first_err_sel,
  output logic [DATA_W-1:0] first_err_data
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RESET, RUN, SCAN, CMP, DONE} state_t;
  state_t state, state_nx, scan_st;
  logic [RW-1:0] rst_cnt;
  logic [CNT_W-1:0] run_cnt, run_limit_q;
  logic halt_en_q;
  logic [DATA_W-1:0] halt_pc_q;
  logic [1:0] lat_cnt;
  logic [SEL_W-1:0] idx;
  logic [DATA_W-1:0] exp_val [NUM_REGS];
  logic [NUM_REGS-1:0] exp_vld;
  logic go, hit, lim, last, mism;
  // Status outputs decode straight from the state so rst restores them at once
  always_comb begin
    cpu_rstn = state != RESET;
    busy = state == RESET || state == RUN || state == SCAN || state == CMP;
    done = state == DONE;
    pass = done && err_count == '0;
    reg_sel = (state == SCAN || state == CMP) ? idx : '0;
  end
  // Next-state logic; SCAN is bypassed entirely when no sample wait is needed
  always_comb begin
    go = start && (state == IDLE || state == DONE);
    hit = halt_en_q && cpu_pc == halt_pc_q;
    lim = run_cnt + CNT_W'(1) == run_limit_q;
    last = idx == SEL_W'(NUM_REGS - 1);
    mism = exp_vld[idx] && exp_val[idx] != reg_data;
    scan_st = SAMPLE_LAT == 0 ? CMP : SCAN;
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = go ? RESET : state;
      RESET: state_nx = rst_cnt == RW'(RST_CYCLES - 1) ? (run_limit_q == '0 ? scan_st : RUN) : RESET;
      RUN: state_nx = (hit || lim) ? scan_st : RUN;
      SCAN: state_nx = lat_cnt == 2'(SAMPLE_LAT - 1) ? CMP : SCAN;
      CMP: state_nx = last ? DONE : scan_st;
      default: state_nx = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // Expected-value table values; only the valid bits need clearing on reset
  always_ff @(posedge clk)
    if (exp_we && {1'b0, exp_addr} < (SEL_W + 1)'(NUM_REGS)) exp_val[exp_addr] <= exp_data;
  // Phase counters, start-time captures, halt flag and mismatch bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_vld <= '0;
      rst_cnt <= '0;
      run_cnt <= '0;
      lat_cnt <= '0;
      idx <= '0;
      run_limit_q <= '0;
      halt_en_q <= 1'b0;
      halt_pc_q <= '0;
      halted <= 1'b0;
      err_count <= '0;
      first_err_sel <= '0;
      first_err_data <= '0;
    end else begin
      if (exp_we && {1'b0, exp_addr} < (SEL_W + 1)'(NUM_REGS)) exp_vld[exp_addr] <= 1'b1;
      rst_cnt <= state == RESET ? rst_cnt + RW'(1) : '0;
      run_cnt <= state == RUN ? run_cnt + CNT_W'(1) : '0;
      lat_cnt <= state == SCAN ? lat_cnt + 2'd1 : '0;
      if (go) begin
        run_limit_q <= run_limit;
        halt_en_q <= halt_en;
        halt_pc_q <= halt_pc;
        halted <= 1'b0;
        err_count <= '0;
        first_err_sel <= '0;
        first_err_data <= '0;
        idx <= '0;
      end
      if (state == RUN && hit) halted <= 1'b1;
      if (state == CMP) begin
        idx <= last ? '0 : idx + SEL_W'(1);
        if (mism) begin
          if (err_count < (SEL_W + 1)'(NUM_REGS)) err_count <= err_count + (SEL_W + 1)'(1);
          if (err_count == '0) begin
            first_err_sel <= idx;
            first_err_data <= reg_data;
          end
        end
      end
    end
  end
endmodule

// File: doc/mccomp_run_checker.md
Name: mccomp_run_checker

Overview:
Synthesizable run-and-check controller for the multi-cycle CPU top (mccomp) and its successors. Sequences a CPU reset pulse and runs the CPU for a bounded number of cycles or until a halt PC is reached. It then scans the CPU register file through the reg_sel/reg_data debug port and compares each register against a loaded expected-value table. The block replaces hand-timed reset/wait/reg_sel stimulus with a parametrised, self-checking sequence usable in simulation and on FPGA.

Parameters:
DATA_W, 32, register/PC data width
SEL_W, 5, reg_sel width
NUM_REGS, 32, registers scanned (1..2**SEL_W)
RST_CYCLES, 2, cycles cpu_rstn held low (>=1)
CNT_W, 16, run-cycle counter width
SAMPLE_LAT, 1, cycles from reg_sel change to valid reg_data (0..3)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begins sequence (ignored unless IDLE or DONE)
run_limit  in  CNT_W  max run cycles, sampled at start; 0 = skip run phase
halt_en  in  1  enable halt-PC detection, sampled at start
halt_pc  in  DATA_W  halt address, sampled at start
cpu_pc  in  DATA_W  CPU program counter
cpu_rstn  out  1  active-low reset to CPU
reg_sel  out  SEL_W  register select to CPU
reg_data  in  DATA_W  selected register value from CPU
exp_we  in  1  expected-table write strobe
exp_addr  in  SEL_W  table index
exp_data  in  DATA_W  expected value
busy  out  1  sequence in progress
done  out  1  sequence complete, held until next start/rst
pass  out  1  done and err_count==0
halted  out  1  run ended by halt-PC match (not by limit)
err_count  out  SEL_W+1  number of mismatching checked registers
first_err_sel  out  SEL_W  index of first mismatch
first_err_data  out  DATA_W  reg_data captured at first mismatch

Behaviour:
- Reset (rst=1 at edge): state IDLE; cpu_rstn=1, reg_sel=0, busy=0, done=0, pass=0, halted=0, err_count=0, first_err_sel=0, first_err_data=0; all table valid bits cleared.
- Table: NUM_REGS entries {valid, value}. exp_we writes value and sets valid for the next cycle. Writes are accepted in any state; a write during CHECK to an index not yet scanned takes effect. exp_addr>=NUM_REGS is ignored. Entries with valid=0 are skipped (never counted as errors).
- FSM: IDLE/DONE -(start)-> RESET.
- RESET: cpu_rstn=0 for exactly RST_CYCLES cycles, then -> RUN with cpu_rstn=1. On start, outputs clear: done, pass, halted, err_count, first_err_*. busy=1 from the cycle after start until the DONE entry.
- RUN: counter increments each cycle from 0. Exit to SCAN when the count reaches run_limit, or when halt_en && cpu_pc==halt_pc; the halt condition sets halted=1. If both occur on the same cycle, halted=1. run_limit=0 skips RUN: RESET goes directly to SCAN.
- SCAN: for idx=0..NUM_REGS-1: drive reg_sel=idx, wait SAMPLE_LAT cycles, then compare on the next cycle (CMP). reg_sel is held stable through the wait and compare.
  - On mismatch with a valid entry: err_count+1; first_err_* is written only when err_count was 0.
  - Cost per register is SAMPLE_LAT+1 cycles; there is no wrap.
  - After idx NUM_REGS-1 -> DONE.
- DONE: done=1, pass=(err_count==0), busy=0, reg_sel=0, cpu_rstn stays 1 (CPU keeps running).
- start while busy is ignored. rst mid-sequence aborts immediately to the reset values above, including cpu_rstn=1.
- err_count saturates at NUM_REGS and cannot overflow.

Test Plan:
- Load exp[1]=5, exp[2]=7; CPU model sets r1=5, r2=7; run_limit=20, halt_en=0 -> cpu_rstn low exactly 2 cycles; DONE after 2+20+32*2 cycles (±1 transition); pass=1, halted=0, err_count=0.
- Same setup but r2=8 -> err_count=1, first_err_sel=2, first_err_data=8, pass=0.
- halt_en=1, halt_pc=0x3C, PC model reaches 0x3C at run cycle 9, run_limit=1000 -> RUN exits at cycle 9, halted=1; a simultaneous limit hit also gives halted=1.
- No table writes, run_limit=0 -> RUN skipped; pass=1, err_count=0; reg_sel visits 0..31, each held SAMPLE_LAT+1 cycles.
- Assert rst during SCAN at idx 10 -> next cycle all outputs at reset values, table cleared; start then runs a fresh sequence. start pulsed during RUN is ignored.
- All 32 entries mismatch -> err_count=32 with no wrap; first_err_sel=0.
